// File: rtl/child_slot_scheduler_pkg.sv
// Shared types and default sizing for the child-slot round-robin scheduler.
// No logic here; imported by the interface, the picker and the top.
package child_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} sched_state_t;

    localparam int N_REQ_DEF    = 10;
    localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/child_slot_scheduler_if.sv
// Request/grant bundle between the child instances (master) and the scheduler (slave).
// Requests are level-sensitive; grant-side signals are all registered in the scheduler.
interface child_slot_scheduler_if
    import child_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = 16
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] rel;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             timeout;
    logic [CNT_W-1:0] grant_count;

    modport master (
        output req, rel,
        input  gnt, gnt_valid, gnt_idx, timeout, grant_count
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_valid, gnt_idx, timeout, grant_count
    );

endinterface

// File: rtl/child_slot_scheduler_rr_pick.sv
// Rotate-priority encoder: first set req after ptr, wrapping modulo N_REQ.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick
    import child_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] w_cand;

    // Walk from the farthest offset down so the nearest candidate is the last writer.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/child_slot_scheduler.sv
// Shares one downstream slot among N_REQ children: 1-cycle grant latency, bounded hold,
// one-cycle gap between owners; requesters simply wait (level req), owner may release early.
module child_slot_scheduler
    import child_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    child_slot_scheduler_if.slave  bus
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic [N_REQ-1:0] r_gnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_count;

    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    logic             w_found;
    logic [IDX_W-1:0] w_win;
    logic             w_hold_max;
    logic             w_busy_end;

    // ptr holds the last owner, so in GAP the previous owner is searched last.
    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_win)
    );

    assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));
    assign w_busy_end = w_hold_max | ~bus.req[r_idx] | bus.rel[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= IDX_W'(N_REQ - 1);
            r_idx     <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_hold    <= w_hold_nxt;
            r_gnt     <= w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
            r_count   <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_GAP: w_state_nxt = w_found ? S_BUSY : S_IDLE;
            S_BUSY:        w_state_nxt = w_busy_end ? S_GAP : S_BUSY;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_hold_nxt    = r_hold;
        w_gnt_nxt     = r_gnt;
        w_timeout_nxt = 1'b0;
        w_count_nxt   = r_count;
        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_found) begin
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_idx_nxt   = w_win;
                    w_ptr_nxt   = w_win;
                    w_hold_nxt  = HOLD_W'(1);
                    w_count_nxt = (r_count == '1) ? r_count : r_count + CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (w_busy_end) begin
                    w_gnt_nxt     = '0;
                    w_timeout_nxt = w_hold_max;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: w_gnt_nxt = '0;
        endcase
    end

    assign bus.gnt         = r_gnt;
    assign bus.gnt_valid   = |r_gnt;
    assign bus.gnt_idx     = r_idx;
    assign bus.timeout     = r_timeout;
    assign bus.grant_count = r_count;

endmodule

// File: tb/tb_child_slot_scheduler.sv
// Bench for child_slot_scheduler: cycle model of the arbitration rules checked every negedge,
// plus directed scenarios with literal expectations.
module tb_child_slot_scheduler;
    import child_sched_pkg::*;

    localparam int N  = 10;
    localparam int MH = 16;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    child_slot_scheduler_if #(.N_REQ(N), .CNT_W(16)) bus ();
    child_slot_scheduler_if #(.N_REQ(N), .CNT_W(4))  bus4 ();

    assign bus4.req = bus.req;
    assign bus4.rel = bus.rel;

    child_slot_scheduler #(.N_REQ(N), .MAX_HOLD(MH), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    child_slot_scheduler #(.N_REQ(N), .MAX_HOLD(MH), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 = none), cycles held, last owner, grants issued.
    int m_owner = -1;
    int m_hold  = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;
    int m_tmo   = 0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        w = pick(bus.req, m_last);
        if (rst) begin
            m_owner <= -1;
            m_hold  <= 0;
            m_last  <= N - 1;
            m_cnt   <= 0;
            m_tmo   <= 0;
        end else if (m_owner >= 0) begin
            if (m_hold == MH) begin
                m_owner <= -1;
                m_last  <= m_owner;
                m_tmo   <= 1;
            end else if (!bus.req[m_owner] || bus.rel[m_owner]) begin
                m_owner <= -1;
                m_last  <= m_owner;
                m_tmo   <= 0;
            end else begin
                m_hold <= m_hold + 1;
                m_tmo  <= 0;
            end
        end else begin
            m_tmo <= 0;
            if (w >= 0) begin
                m_owner <= w;
                m_hold  <= 1;
                m_cnt   <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e;
        if (chk_en) begin
            e = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk("gnt", 64'(bus.gnt), 64'(e));
            chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'(1));
            chk("gnt_valid", 64'(bus.gnt_valid), 64'(m_owner >= 0));
            chk("timeout", 64'(bus.timeout), 64'(m_tmo));
            chk("grant_count", 64'(bus.grant_count), 64'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("grant_count_w4", 64'(bus4.grant_count), 64'((m_cnt > 15) ? 15 : m_cnt));
            chk("gnt_w4", 64'(bus4.gnt), 64'(e));
            if (m_owner >= 0) chk("gnt_idx", 64'(bus.gnt_idx), 64'(m_owner));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_grant(input int budget, output int idx);
        int n = 0;
        while (bus.gnt == '0 && n < budget) begin
            step();
            n++;
        end
        if (bus.gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: no grant within %0d cycles at %0t", budget, $time);
        end
        idx = oh2i(bus.gnt);
    endtask

    // Measures the gap before the next grant, its owner, length, and timeout in the cycle after.
    task automatic measure(output int idx, output int len, output int gap, output int tmo);
        logic [N-1:0] cur;
        gap = 0;
        while (bus.gnt == '0 && gap < 400) begin
            step();
            gap++;
        end
        cur = bus.gnt;
        idx = oh2i(cur);
        len = 0;
        while (cur != '0 && bus.gnt == cur && len < 400) begin
            len++;
            step();
        end
        tmo = int'(bus.timeout);
        if (cur == '0 || len >= 400) begin
            checks++;
            errors++;
            $display("FAIL measure: grant missing or stuck at %0t", $time);
        end
    endtask

    initial begin
        int idx, len, gap, tmo;
        rst     = 1'b1;
        bus.req = '0;
        bus.rel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_gnt", 64'(bus.gnt), 64'(0));
        chk("reset_gnt_valid", 64'(bus.gnt_valid), 64'(0));
        chk("reset_gnt_idx", 64'(bus.gnt_idx), 64'(0));
        chk("reset_timeout", 64'(bus.timeout), 64'(0));
        chk("reset_grant_count", 64'(bus.grant_count), 64'(0));

        // Single requester: one-cycle grant latency, then release by dropping req.
        rst     = 1'b0;
        bus.req = 10'b0000000001;
        step();
        chk("first_gnt", 64'(bus.gnt), 64'(1));
        chk("first_gnt_idx", 64'(bus.gnt_idx), 64'(0));
        chk("first_grant_count", 64'(bus.grant_count), 64'(1));
        bus.req = '0;
        step();
        chk("drop_gnt", 64'(bus.gnt), 64'(0));
        chk("drop_timeout", 64'(bus.timeout), 64'(0));
        step();

        // Requesters 3 and 7 alternate on timeout.
        bus.req = 10'b0010001000;
        measure(idx, len, gap, tmo);
        chk("p37_a_idx", 64'(idx), 64'(3));
        chk("p37_a_len", 64'(len), 64'(MH));
        chk("p37_a_tmo", 64'(tmo), 64'(1));
        measure(idx, len, gap, tmo);
        chk("p37_b_idx", 64'(idx), 64'(7));
        chk("p37_b_len", 64'(len), 64'(MH));
        chk("p37_b_gap", 64'(gap), 64'(1));
        chk("p37_b_tmo", 64'(tmo), 64'(1));
        measure(idx, len, gap, tmo);
        chk("p37_c_idx", 64'(idx), 64'(3));
        chk("p37_c_gap", 64'(gap), 64'(1));
        bus.req = '0;
        repeat (2) step();

        // All ten requesting: order 0..9 then wrap to 0.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = '1;
        for (int i = 0; i <= N; i++) begin
            measure(idx, len, gap, tmo);
            chk("all_idx", 64'(idx), 64'(i % N));
            chk("all_len", 64'(len), 64'(MH));
            chk("all_tmo", 64'(tmo), 64'(1));
            if (i > 0) chk("all_gap", 64'(gap), 64'(1));
        end
        bus.req = '0;
        repeat (2) step();

        // Early release by owner 2 at hold cycle 4; rel[5] from a non-owner ignored.
        bus.req = 10'b0000000100;
        wait_grant(8, idx);
        chk("rel_owner", 64'(idx), 64'(2));
        step();
        bus.rel = 10'b0000100000;
        step();
        bus.rel = '0;
        chk("rel_nonowner_gnt", 64'(bus.gnt), 64'(10'b0000000100));
        step();
        bus.rel = 10'b0000000100;
        step();
        bus.rel = '0;
        bus.req = '0;
        chk("rel_gnt_drop", 64'(bus.gnt), 64'(0));
        chk("rel_no_timeout", 64'(bus.timeout), 64'(0));
        repeat (2) step();

        // Reset in the middle of a grant at hold cycle 8.
        bus.req = 10'b0000010000;
        wait_grant(8, idx);
        chk("rst_owner", 64'(idx), 64'(4));
        repeat (7) step();
        rst = 1'b1;
        step();
        chk("rst_mid_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_mid_valid", 64'(bus.gnt_valid), 64'(0));
        chk("rst_mid_idx", 64'(bus.gnt_idx), 64'(0));
        chk("rst_mid_timeout", 64'(bus.timeout), 64'(0));
        chk("rst_mid_count", 64'(bus.grant_count), 64'(0));
        rst     = 1'b0;
        bus.req = '1;
        wait_grant(8, idx);
        chk("rst_then_first", 64'(idx), 64'(0));
        bus.req = '0;
        repeat (2) step();

        // Twenty single-cycle grants: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            bus.req = N'(1) << (i % N);
            wait_grant(8, idx);
            bus.req = '0;
            step();
        end
        step();
        chk("sat_count16", 64'(bus.grant_count), 64'(21));
        chk("sat_count4", 64'(bus4.grant_count), 64'(15));

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
